hasti_mbist_march: RTL and testbench



---
 rtl/hasti_mbist_march_if.sv | 24 ++
 rtl/hasti_mbist_march.sv | 196 +++++++++++++++++++
 tb/tb_hasti_mbist_march.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hasti_mbist_march_if.sv
// AHB-Lite (HASTI) bus bundle between the MBIST master and the SRAM test port.
interface hasti_mbist_march_if;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic [1:0]  htrans;
   logic        hmastlock;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;

   modport master (
      output haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
      input  hrdata, hready, hresp
   );

   modport slave (
      input  haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
      output hrdata, hready, hresp
   );
endinterface

// File: rtl/hasti_mbist_march.sv
// AHB-Lite memory BIST master: address-as-data, checkerboard or March C- over a word window,
// with saturating error count and first-failure capture.
module hasti_mbist_march #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned NUM_WORDS = 256,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                io_start,
   input  logic [1:0]          io_mode,
   output logic                io_busy,
   output logic                io_done,
   output logic                io_pass,
   output logic [CNT_W-1:0]    io_err_count,
   output logic [31:0]         io_fail_addr,
   output logic [31:0]         io_fail_data,
   hasti_mbist_march_if.master bus
);
   localparam int unsigned      IDX_W    = $clog2(NUM_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   typedef enum logic [2:0] {StIdle, StAddr, StData, StNext, StDone} state_e;
   typedef enum logic [1:0] {AlgAddr, AlgChecker, AlgMarch} alg_e;

   state_e           state_q, state_d;
   alg_e             alg_q, alg_d;
   logic [2:0]       elem_q, elem_d;
   logic             op_q, op_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [31:0]      fail_addr_q, fail_addr_d;
   logic [31:0]      fail_data_q, fail_data_d;

   logic [31:0] cur_addr;
   logic [31:0] cur_data;
   logic        cur_write;
   logic        march_bit;
   logic [2:0]  last_elem;
   logic [2:0]  elem_inc;
   logic        cur_down;
   logic        last_op;
   logic        last_idx;
   logic        xfer_fail;

   function automatic logic elem_is_down(alg_e alg, logic [2:0] elem);
      return (alg == AlgMarch) && (elem == 3'd3 || elem == 3'd4);
   endfunction

   // Decode the current element/op into direction, access type and expected pattern.
   always_comb begin
      cur_write = 1'b0;
      cur_data  = '0;
      march_bit = 1'b0;
      last_elem = 3'd1;
      case (alg_q)
         AlgAddr: begin
            cur_write = (elem_q == 3'd0);
            cur_data  = 32'(idx_q);
            last_elem = 3'd1;
         end
         AlgChecker: begin
            cur_write = ~elem_q[0];
            cur_data  = idx_q[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
            if (elem_q[1]) cur_data = ~cur_data;
            last_elem = 3'd3;
         end
         default: begin
            // Middle elements are (read, write) pairs; elements 1/3 read 0 and write 1.
            case (elem_q)
               3'd0: begin
                  cur_write = 1'b1;
                  march_bit = 1'b0;
               end
               3'd1, 3'd3: begin
                  cur_write = op_q;
                  march_bit = op_q;
               end
               3'd2, 3'd4: begin
                  cur_write = op_q;
                  march_bit = ~op_q;
               end
               default: begin
                  cur_write = 1'b0;
                  march_bit = 1'b0;
               end
            endcase
            cur_data  = {32{march_bit}};
            last_elem = 3'd5;
         end
      endcase
   end

   assign cur_addr  = BASE_ADDR + (32'(idx_q) << 2);
   assign cur_down  = elem_is_down(alg_q, elem_q);
   assign elem_inc  = elem_q + 3'd1;
   assign last_op   = (alg_q != AlgMarch) || (elem_q == 3'd0) || (elem_q == 3'd5) || op_q;
   assign last_idx  = cur_down ? (idx_q == '0) : (idx_q == LAST_IDX);
   assign xfer_fail = bus.hresp || (!cur_write && (bus.hrdata != cur_data));

   always_comb begin
      state_d     = state_q;
      alg_d       = alg_q;
      elem_d      = elem_q;
      op_d        = op_q;
      idx_d       = idx_q;
      err_d       = err_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;
      case (state_q)
         StIdle, StDone: begin
            if (io_start) begin
               alg_d       = (io_mode == 2'd0) ? AlgAddr :
                             (io_mode == 2'd1) ? AlgChecker : AlgMarch;
               elem_d      = '0;
               op_d        = 1'b0;
               idx_d       = '0;
               err_d       = '0;
               fail_addr_d = '0;
               fail_data_d = '0;
               state_d     = StAddr;
            end
         end
         StAddr: begin
            if (bus.hready) state_d = StData;
         end
         StData: begin
            if (bus.hready) begin
               state_d = StNext;
               if (xfer_fail) begin
                  if (err_q != {CNT_W{1'b1}}) err_d = err_q + CNT_W'(1);
                  if (err_q == '0) begin
                     fail_addr_d = cur_addr;
                     fail_data_d = bus.hrdata;
                  end
               end
            end
         end
         StNext: begin
            state_d = StAddr;
            if (!last_op) begin
               op_d = 1'b1;
            end else begin
               op_d = 1'b0;
               if (!last_idx) begin
                  idx_d = cur_down ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
               end else if (elem_q == last_elem) begin
                  state_d = StDone;
               end else begin
                  elem_d = elem_inc;
                  idx_d  = elem_is_down(alg_q, elem_inc) ? LAST_IDX : '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         alg_q       <= AlgAddr;
         elem_q      <= '0;
         op_q        <= 1'b0;
         idx_q       <= '0;
         err_q       <= '0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
      end else begin
         state_q     <= state_d;
         alg_q       <= alg_d;
         elem_q      <= elem_d;
         op_q        <= op_d;
         idx_q       <= idx_d;
         err_q       <= err_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
      end
   end

   assign io_busy      = (state_q == StAddr) || (state_q == StData) || (state_q == StNext);
   assign io_done      = (state_q == StDone);
   assign io_pass      = io_done && (err_q == '0);
   assign io_err_count = err_q;
   assign io_fail_addr = fail_addr_q;
   assign io_fail_data = fail_data_q;

   assign bus.haddr     = cur_addr;
   assign bus.hwrite    = (state_q == StAddr) && cur_write;
   assign bus.hsize     = 3'h2;
   assign bus.hburst    = 3'h0;
   assign bus.hprot     = 4'h3;
   assign bus.htrans    = (state_q == StAddr) ? 2'h2 : 2'h0;
   assign bus.hmastlock = 1'b0;
   assign bus.hwdata    = cur_data;
endmodule

// File: tb/tb_hasti_mbist_march.sv
// Bench for hasti_mbist_march: SRAM slave with stuck-at/error injection and random waits,
// checked against a transfer-list model built from the algorithm definitions.
module tb_hasti_mbist_march;
   localparam logic [31:0] BASE    = 32'h0000_1000;
   localparam int          NW      = 256;
   localparam int          CW      = 3;
   localparam int          ERR_MAX = (1 << CW) - 1;
   localparam int          LIMIT   = 20000;
   localparam logic [31:0] ONES    = 32'hFFFF_FFFF;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          io_start = 1'b0;
   logic [1:0]    io_mode = 2'd0;
   logic          io_busy, io_done, io_pass;
   logic [CW-1:0] io_err_count;
   logic [31:0]   io_fail_addr, io_fail_data;

   hasti_mbist_march_if bus ();

   hasti_mbist_march #(.BASE_ADDR(BASE), .NUM_WORDS(NW), .CNT_W(CW)) dut (
      .clk          (clk),
      .reset        (reset),
      .io_start     (io_start),
      .io_mode      (io_mode),
      .io_busy      (io_busy),
      .io_done      (io_done),
      .io_pass      (io_pass),
      .io_err_count (io_err_count),
      .io_fail_addr (io_fail_addr),
      .io_fail_data (io_fail_data),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] data;
   } xfer_t;

   xfer_t       exp_q[$];
   xfer_t       obs_q[$];
   logic [31:0] mem[NW];
   logic [31:0] stuck[NW];
   int          resp_xfer = -1;
   int          xfer_num = 0;
   int          hold_err = 0;
   bit          stall_en = 1'b0;
   bit          force_stall = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          exp_err;
   logic [31:0] exp_faddr, exp_fdata;

   // SRAM slave: one data phase after each accepted NONSEQ, stuck-at-1 masks applied on read.
   initial begin : slave
      logic [31:0] h_addr, p_addr, held_wd;
      logic        h_wr, p_wr;
      bit          pending, in_addr, first_data;
      int          zeros, widx;
      xfer_t       x;
      pending = 0; in_addr = 0; first_data = 0; zeros = 0;
      h_addr = '0; p_addr = '0; held_wd = '0; h_wr = 0; p_wr = 0;
      bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;
      for (int i = 0; i < NW; i++) mem[i] = $urandom;
      forever begin
         @(negedge clk);
         if (!reset) begin
            pending = 0; in_addr = 0; bus.hready = 1'b1; bus.hresp = 1'b0;
         end else begin
            if (force_stall) bus.hready = 1'b0;
            else if (stall_en && zeros < 3 && $urandom_range(0, 1) == 1) begin
               bus.hready = 1'b0; zeros++;
            end else begin
               bus.hready = 1'b1; zeros = 0;
            end
            bus.hresp = 1'b0;
            if (pending) begin
               widx = int'(((p_addr - BASE) >> 2) & 32'(NW - 1));
               if (first_data) held_wd = bus.hwdata;
               else if (bus.hwdata !== held_wd) hold_err++;
               first_data = 0;
               bus.hresp  = (xfer_num == resp_xfer);
               bus.hrdata = p_wr ? 32'hDEAD_BEEF : (mem[widx] | stuck[widx]);
               if (bus.hready) begin
                  if (p_wr) mem[widx] = bus.hwdata;
                  x.addr = p_addr; x.wr = p_wr; x.data = bus.hwdata;
                  obs_q.push_back(x);
                  xfer_num++;
                  pending = 0;
               end
            end else if (bus.htrans == 2'h2) begin
               if (in_addr && (bus.haddr !== h_addr || bus.hwrite !== h_wr)) hold_err++;
               h_addr  = bus.haddr;
               h_wr    = bus.hwrite;
               in_addr = !bus.hready;
               if (bus.hready) begin
                  pending = 1; first_data = 1; p_addr = h_addr; p_wr = h_wr;
               end
            end else begin
               if (in_addr) hold_err++;
               in_addr = 0;
            end
         end
      end
   end

   task automatic push_x(input int i, input bit wr, input logic [31:0] d);
      xfer_t x;
      x.addr = BASE + 32'(i) * 32'd4; x.wr = wr; x.data = d;
      exp_q.push_back(x);
   endtask

   function automatic logic [31:0] chk(input int i, input int p);
      return ((i % 2) == 1 ? 32'hAAAA_AAAA : 32'h5555_5555) ^ (p == 1 ? ONES : 32'h0);
   endfunction

   // Expected transfer list straight from the element definitions.
   task automatic build_expected(input int mode);
      exp_q.delete();
      if (mode == 0) begin
         for (int i = 0; i < NW; i++) push_x(i, 1, 32'(i));
         for (int i = 0; i < NW; i++) push_x(i, 0, 32'(i));
      end else if (mode == 1) begin
         for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NW; i++) push_x(i, 1, chk(i, p));
            for (int i = 0; i < NW; i++) push_x(i, 0, chk(i, p));
         end
      end else begin
         for (int i = 0; i < NW; i++) push_x(i, 1, 32'h0);
         for (int i = 0; i < NW; i++) begin push_x(i, 0, 32'h0); push_x(i, 1, ONES); end
         for (int i = 0; i < NW; i++) begin push_x(i, 0, ONES); push_x(i, 1, 32'h0); end
         for (int i = NW - 1; i >= 0; i--) begin push_x(i, 0, 32'h0); push_x(i, 1, ONES); end
         for (int i = NW - 1; i >= 0; i--) begin push_x(i, 0, ONES); push_x(i, 1, 32'h0); end
         for (int i = 0; i < NW; i++) push_x(i, 0, 32'h0);
      end
   endtask

   task automatic predict();
      logic [31:0] mm[NW];
      logic [31:0] rd;
      bit          fail;
      int          w;
      exp_err = 0; exp_faddr = '0; exp_fdata = '0;
      foreach (exp_q[k]) begin
         w    = int'((exp_q[k].addr - BASE) >> 2);
         fail = (k == resp_xfer);
         if (exp_q[k].wr) begin
            mm[w] = exp_q[k].data; rd = 32'hDEAD_BEEF;
         end else begin
            rd = mm[w] | stuck[w];
            if (rd != exp_q[k].data) fail = 1;
         end
         if (fail) begin
            if (exp_err == 0) begin exp_faddr = exp_q[k].addr; exp_fdata = rd; end
            if (exp_err < ERR_MAX) exp_err++;
         end
      end
   endtask

   function automatic int seq_diffs(output int first);
      int n;
      n = 0; first = -1;
      for (int k = 0; k < exp_q.size() || k < obs_q.size(); k++) begin
         if (k >= exp_q.size() || k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
            if (first < 0) first = k;
            n++;
         end
      end
      return n;
   endfunction

   task automatic run_dut(input logic [1:0] mode, input int pulse_at, output int cycles,
                          output bit timed_out, output logic [1:0] first);
      @(negedge clk);
      obs_q.delete(); xfer_num = 0; hold_err = 0;
      io_start = 1'b1; io_mode = mode;
      @(negedge clk);
      io_start = 1'b0; io_mode = 2'($urandom);
      first  = {io_busy, io_done};
      cycles = 0;
      while (io_done !== 1'b1 && cycles < LIMIT) begin
         @(negedge clk);
         cycles++;
         io_start = (cycles == pulse_at);
         if (cycles == pulse_at) io_mode = (mode == 2'd0) ? 2'd2 : 2'd0;
      end
      io_start  = 1'b0;
      timed_out = (io_done !== 1'b1);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      #1;
      n_tests++;
      if ({io_busy, io_done, io_pass, io_err_count, io_fail_addr, io_fail_data, bus.htrans} !== '0)
      begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b pass=%b err=%0d fa=%h fd=%h htrans=%h want 0",
                  io_busy, io_done, io_pass, io_err_count, io_fail_addr, io_fail_data, bus.htrans);
      end
      n_tests++;
      if ({bus.hsize, bus.hburst, bus.hprot, bus.hmastlock} !== {3'h2, 3'h0, 4'h3, 1'b0}) begin
         n_fail++;
         $display("FAIL bus_consts: got %h %h %h %b want 2 0 3 0",
                  bus.hsize, bus.hburst, bus.hprot, bus.hmastlock);
      end
      @(negedge clk); reset = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({io_busy, io_done, bus.htrans} !== '0) begin
         n_fail++;
         $display("FAIL idle_no_start: busy=%b done=%b htrans=%h want 0", io_busy, io_done,
                  bus.htrans);
      end
   endtask

   task automatic test_addr_mode();
      int cyc, first; bit to; logic [1:0] b0; int nd, lw;
      build_expected(0); predict();
      run_dut(2'd0, -1, cyc, to, b0);
      n_tests++;
      if (to || cyc !== 1536) begin
         n_fail++; $display("FAIL addr_cycles: got %0d want %0d", cyc, 1536);
      end
      nd = seq_diffs(first);
      n_tests++;
      if (nd !== 0) begin
         n_fail++; $display("FAIL addr_sequence: got %0d diffs (first at %0d) want 0", nd, first);
      end
      n_tests++;
      if ({io_pass, io_err_count} !== {1'b1, 3'd0}) begin
         n_fail++; $display("FAIL addr_pass: got pass=%b err=%0d want 1 0", io_pass, io_err_count);
      end
      lw = -1;
      foreach (obs_q[k]) if (obs_q[k].wr) lw = k;
      n_tests++;
      if (lw < 0 || obs_q[lw].addr !== BASE + 32'h3FC || obs_q[lw].data !== 32'hFF) begin
         n_fail++; $display("FAIL addr_last_write: index %0d want addr %h data ff", lw, BASE + 32'h3FC);
      end
   endtask

   task automatic test_march_ideal();
      int cyc, first; bit to; logic [1:0] b0; int nd;
      build_expected(2); predict();
      run_dut(2'($urandom_range(2, 3)), -1, cyc, to, b0);
      n_tests++;
      if (b0 !== 2'b10) begin
         n_fail++; $display("FAIL back_to_back: got busy,done=%b want 10", b0);
      end
      nd = seq_diffs(first);
      n_tests++;
      if (to || nd !== 0 || obs_q.size() !== 2560) begin
         n_fail++; $display("FAIL march_sequence: got %0d diffs, %0d xfers want 0, 2560", nd,
                            obs_q.size());
      end
      n_tests++;
      if (obs_q.size() < 1281 || obs_q[1280].addr !== BASE + 32'h3FC || obs_q[1280].wr !== 1'b0)
      begin
         n_fail++; $display("FAIL march_elem3_start: want read at %h", BASE + 32'h3FC);
      end
      n_tests++;
      if ({io_done, io_pass, io_err_count} !== {1'b1, 1'b1, 3'd0}) begin
         n_fail++; $display("FAIL march_pass: got done=%b pass=%b err=%0d want 1 1 0", io_done,
                            io_pass, io_err_count);
      end
   endtask

   task automatic test_march_stuck();
      int cyc, first; bit to; logic [1:0] b0; int nd;
      stuck[10] = 32'h10;
      build_expected(3); predict();
      run_dut(2'd3, -1, cyc, to, b0);
      n_tests++;
      if (to || io_err_count !== 3'd3 || int'(io_err_count) !== exp_err) begin
         n_fail++; $display("FAIL stuck_err_count: got %0d want 3", io_err_count);
      end
      n_tests++;
      if (io_fail_addr !== 32'h1028 || io_fail_data !== 32'h10) begin
         n_fail++; $display("FAIL stuck_capture: got addr %h data %h want 1028 10", io_fail_addr,
                            io_fail_data);
      end
      n_tests++;
      if ({io_done, io_pass} !== 2'b10) begin
         n_fail++; $display("FAIL stuck_pass: got done,pass=%b want 10", {io_done, io_pass});
      end
      nd = seq_diffs(first);
      n_tests++;
      if (nd !== 0) begin
         n_fail++; $display("FAIL stuck_sequence: got %0d diffs (first %0d) want 0", nd, first);
      end
      stuck[10] = '0;
   endtask

   task automatic test_checker_resp();
      int cyc, first; bit to; logic [1:0] b0; int nd;
      resp_xfer = 0;
      build_expected(1); predict();
      run_dut(2'd1, -1, cyc, to, b0);
      n_tests++;
      if (to || io_done !== 1'b1 || io_err_count < 3'd1 || int'(io_err_count) !== exp_err) begin
         n_fail++; $display("FAIL resp_err: got done=%b err=%0d want 1 %0d", io_done, io_err_count,
                            exp_err);
      end
      n_tests++;
      if (io_fail_addr !== BASE || io_fail_data !== exp_fdata || io_pass !== 1'b0) begin
         n_fail++; $display("FAIL resp_capture: got addr %h data %h pass %b want %h %h 0",
                            io_fail_addr, io_fail_data, io_pass, BASE, exp_fdata);
      end
      nd = seq_diffs(first);
      n_tests++;
      if (nd !== 0) begin
         n_fail++; $display("FAIL checker_sequence: got %0d diffs (first %0d) want 0", nd, first);
      end
      resp_xfer = -1;
   endtask

   task automatic test_stalls();
      int cyc, first; bit to; logic [1:0] b0; int nd;
      stall_en = 1'b1;
      for (int m = 0; m < 2; m++) begin
         build_expected(1 - m); predict();
         run_dut(2'(1 - m), 100, cyc, to, b0);
         nd = seq_diffs(first);
         n_tests++;
         if (to || nd !== 0) begin
            n_fail++; $display("FAIL stall_sequence_%0d: got %0d diffs (first %0d) want 0", m, nd,
                               first);
         end
         n_tests++;
         if (hold_err !== 0) begin
            n_fail++; $display("FAIL stall_hold_%0d: got %0d hold violations want 0", m, hold_err);
         end
         n_tests++;
         if ({io_pass, io_err_count} !== {1'b1, 3'd0} || cyc <= 3 * exp_q.size()) begin
            n_fail++; $display("FAIL stall_pass_%0d: got pass=%b err=%0d cycles=%0d want 1 0 >%0d",
                               m, io_pass, io_err_count, cyc, 3 * exp_q.size());
         end
      end
      stall_en = 1'b0;
   endtask

   task automatic test_saturate();
      int cyc; bit to; logic [1:0] b0;
      stuck[10] = 32'h10; stuck[20] = 32'h10; stuck[30] = 32'h10;
      build_expected(2); predict();
      run_dut(2'd2, -1, cyc, to, b0);
      n_tests++;
      if (to || int'(io_err_count) !== ERR_MAX || exp_err !== ERR_MAX) begin
         n_fail++; $display("FAIL saturate: got %0d want %0d", io_err_count, ERR_MAX);
      end
      n_tests++;
      if (io_fail_addr !== BASE + 32'h28 || io_pass !== 1'b0) begin
         n_fail++; $display("FAIL saturate_capture: got addr %h pass %b want %h 0", io_fail_addr,
                            io_pass, BASE + 32'h28);
      end
      stuck[10] = '0; stuck[20] = '0; stuck[30] = '0;
   endtask

   task automatic test_reset_mid();
      int cyc, first, n; bit to; logic [1:0] b0; int nd;
      stuck[10] = 32'h10;
      @(negedge clk); io_start = 1'b1; io_mode = 2'd2;
      @(negedge clk); io_start = 1'b0;
      n = 0;
      while (io_err_count == '0 && n < LIMIT) begin @(negedge clk); n++; end
      n_tests++;
      if (io_err_count == '0 || io_busy !== 1'b1) begin
         n_fail++; $display("FAIL mid_setup: got err=%0d busy=%b want >0 1", io_err_count, io_busy);
      end
      force_stall = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      n_tests++;
      if ({io_busy, io_done, io_pass, io_err_count, io_fail_addr, io_fail_data, bus.htrans} !== '0)
      begin
         n_fail++;
         $display("FAIL mid_reset_state: busy=%b done=%b err=%0d fa=%h fd=%h htrans=%h want 0",
                  io_busy, io_done, io_err_count, io_fail_addr, io_fail_data, bus.htrans);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1; force_stall = 1'b0; stuck[10] = '0;
      build_expected(2); predict();
      run_dut(2'd2, -1, cyc, to, b0);
      nd = seq_diffs(first);
      n_tests++;
      if (to || nd !== 0 || obs_q.size() == 0 || obs_q[0].addr !== BASE) begin
         n_fail++; $display("FAIL restart_sequence: got %0d diffs (first %0d) want 0", nd, first);
      end
      n_tests++;
      if ({io_pass, io_err_count} !== {1'b1, 3'd0}) begin
         n_fail++; $display("FAIL restart_pass: got pass=%b err=%0d want 1 0", io_pass,
                            io_err_count);
      end
   endtask

   initial begin
      for (int i = 0; i < NW; i++) stuck[i] = '0;
      test_reset();
      test_addr_mode();
      test_march_ideal();
      test_march_stuck();
      test_checker_resp();
      test_stalls();
      test_saturate();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
